// File: rtl/scrambler_session_ctrl.sv
// Session sequencer for the line-rotation scrambler: DRBG reset/init, key latch, rotator gating and reseed pacing.
// Optional: define SCRAMBLER_CTRL_WATCHDOG_EN to fault when a deferred next_seed stays blocked for a full field.
module scrambler_session_ctrl #(
    parameter int INIT_TIMEOUT  = 4096,
    parameter int RESEED_FIELDS = 1,
    parameter int FCNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              V,
    input  logic              F,
    input  logic              enable,
    input  logic              key_load,
    input  logic [255:0]      key_in,
    input  logic              init_ready,
    input  logic              generator_busy,
    output logic [255:0]      entropy,
    output logic              drbg_reset_n,
    output logic              next_seed,
    output logic              rotator_reset_n,
    output logic              bypass,
    output logic [FCNT_W-1:0] field_count,
    output logic              fault
);

    localparam int TMO_W = $clog2(INIT_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DRBG_RST, S_WAIT_INIT, S_WAIT_FIELD, S_RUN, S_FAULT
    } state_t;

    state_t             state_r, state_nx_s;
    logic               v_q_r, v_rise_s;
    logic               key_valid_r;
    logic               rst_cnt_r;
    logic [TMO_W-1:0]   tmo_r;
    logic [7:0]         div_r, div_nx_s;
    logic               pend_r, pend_nx_s;
    logic               seed_req_s, seed_fire_s, rot_pulse_s, count_s;
    logic [255:0]       entropy_r;
    logic               drbg_reset_n_r, next_seed_r, rotator_reset_n_r, bypass_r, fault_r;
    logic [FCNT_W-1:0]  field_count_r;

    assign v_rise_s = V & ~v_q_r;

    // Next-state, field divider and reseed arbitration
    always_comb begin
        state_nx_s  = state_r;
        div_nx_s    = div_r;
        pend_nx_s   = pend_r;
        seed_req_s  = 1'b0;
        seed_fire_s = 1'b0;
        rot_pulse_s = 1'b0;
        count_s     = 1'b0;
        if (key_load) begin
            state_nx_s = enable ? S_DRBG_RST : S_IDLE;
        end else if (!enable && (state_r != S_FAULT)) begin
            state_nx_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (key_valid_r) state_nx_s = S_DRBG_RST;
                    else             state_nx_s = S_IDLE;
                end
                S_DRBG_RST: begin
                    if (rst_cnt_r) state_nx_s = S_WAIT_INIT;
                    else           state_nx_s = S_DRBG_RST;
                end
                S_WAIT_INIT: begin
                    if (init_ready)                               state_nx_s = S_WAIT_FIELD;
                    else if (tmo_r == TMO_W'(INIT_TIMEOUT - 1))   state_nx_s = S_FAULT;
                    else                                          state_nx_s = S_WAIT_INIT;
                end
                S_WAIT_FIELD: begin
                    if (v_rise_s && !F) state_nx_s = S_RUN;
                    else                state_nx_s = S_WAIT_FIELD;
                end
                S_RUN: begin
                    if (v_rise_s) begin
                        count_s     = 1'b1;
                        rot_pulse_s = 1'b1;
                        if (div_r == 8'(RESEED_FIELDS - 1)) begin
                            seed_req_s = 1'b1;
                            div_nx_s   = 8'd0;
                        end else begin
                            div_nx_s   = div_r + 8'd1;
                        end
                    end else begin
                        div_nx_s = div_r;
                    end
                    // A blocked reseed is held (at most one) and released on the first idle cycle
                    if (seed_req_s || pend_r) begin
                        if (generator_busy) begin
                            pend_nx_s   = 1'b1;
                            seed_fire_s = 1'b0;
                        end else begin
                            pend_nx_s   = 1'b0;
                            seed_fire_s = 1'b1;
                        end
                    end else begin
                        pend_nx_s = 1'b0;
                    end
`ifdef SCRAMBLER_CTRL_WATCHDOG_EN
                    if (v_rise_s && pend_r && generator_busy) state_nx_s = S_FAULT;
                    else                                      state_nx_s = S_RUN;
`else
                    state_nx_s = S_RUN;
`endif
                end
                S_FAULT: state_nx_s = S_FAULT;
                default: state_nx_s = S_IDLE;
            endcase
        end
    end

    // State, counters, key latch and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r           <= S_IDLE;
            v_q_r             <= 1'b0;
            key_valid_r       <= 1'b0;
            rst_cnt_r         <= 1'b0;
            tmo_r             <= '0;
            div_r             <= 8'd0;
            pend_r            <= 1'b0;
            entropy_r         <= 256'd0;
            drbg_reset_n_r    <= 1'b0;
            next_seed_r       <= 1'b0;
            rotator_reset_n_r <= 1'b0;
            bypass_r          <= 1'b1;
            field_count_r     <= '0;
            fault_r           <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            v_q_r       <= V;
            if (key_load) begin
                entropy_r   <= key_in;
                key_valid_r <= 1'b1;
            end
            rst_cnt_r <= (state_r == S_DRBG_RST) && (state_nx_s == S_DRBG_RST) && !key_load;
            tmo_r     <= ((state_r == S_WAIT_INIT) && (state_nx_s == S_WAIT_INIT)) ? tmo_r + TMO_W'(1) : '0;
            div_r     <= (state_nx_s == S_RUN) ? div_nx_s : 8'd0;
            pend_r    <= (state_nx_s == S_RUN) ? pend_nx_s : 1'b0;
            if (key_load)     field_count_r <= '0;
            else if (count_s) field_count_r <= field_count_r + FCNT_W'(1);
            drbg_reset_n_r    <= (state_nx_s == S_WAIT_INIT) || (state_nx_s == S_WAIT_FIELD) || (state_nx_s == S_RUN);
            next_seed_r       <= seed_fire_s;
            rotator_reset_n_r <= (state_nx_s == S_RUN) && !rot_pulse_s;
            bypass_r          <= (state_nx_s != S_RUN);
            fault_r           <= (state_nx_s == S_FAULT);
        end
    end

    assign entropy         = entropy_r;
    assign drbg_reset_n    = drbg_reset_n_r;
    assign next_seed       = next_seed_r;
    assign rotator_reset_n = rotator_reset_n_r;
    assign bypass          = bypass_r;
    assign field_count     = field_count_r;
    assign fault           = fault_r;

endmodule

// File: tb/tb_scrambler_session_ctrl.sv
// Directed bench for scrambler_session_ctrl (RESEED_FIELDS=2, INIT_TIMEOUT=4096).
module tb_scrambler_session_ctrl;

    logic         clk = 1'b0;
    logic         reset_n, V, F, enable, key_load, init_ready, generator_busy;
    logic [255:0] key_in;
    logic [255:0] entropy;
    logic         drbg_reset_n, next_seed, rotator_reset_n, bypass, fault;
    logic [15:0]  field_count;
    int           total = 0;
    int           bad = 0;

    localparam logic [255:0] K1 = {8{32'hA5C3_1F07}};
    localparam logic [255:0] K2 = {4{64'h0123_4567_89AB_CDEF}};

    scrambler_session_ctrl #(.INIT_TIMEOUT(4096), .RESEED_FIELDS(2), .FCNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .V(V), .F(F), .enable(enable),
        .key_load(key_load), .key_in(key_in), .init_ready(init_ready),
        .generator_busy(generator_busy), .entropy(entropy), .drbg_reset_n(drbg_reset_n),
        .next_seed(next_seed), .rotator_reset_n(rotator_reset_n), .bypass(bypass),
        .field_count(field_count), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One field: V low for a few cycles, then V rises; checks the rise edge and the cycle after
    task automatic field(input int n, input logic exp_seed);
        V = 1'b0;
        repeat (3) tick();
        V = 1'b1;
        tick();
        check($sformatf("fc_f%0d", n), field_count, 256'(n));
        check($sformatf("seed_f%0d", n), next_seed, 256'(exp_seed));
        check($sformatf("rotpulse_f%0d", n), rotator_reset_n, 256'd0);
        tick();
        check($sformatf("seed_after_f%0d", n), next_seed, 256'd0);
        check($sformatf("rot_after_f%0d", n), rotator_reset_n, 256'd1);
    endtask

    initial begin
        reset_n = 1'b0; V = 1'b0; F = 1'b0; enable = 1'b0; key_load = 1'b0;
        key_in = 256'd0; init_ready = 1'b0; generator_busy = 1'b0;
        tick(); tick();
        check("rst_entropy", entropy, 256'd0);
        check("rst_drbg", drbg_reset_n, 256'd0);
        check("rst_seed", next_seed, 256'd0);
        check("rst_rot", rotator_reset_n, 256'd0);
        check("rst_bypass", bypass, 256'd1);
        check("rst_fc", field_count, 256'd0);
        check("rst_fault", fault, 256'd0);

        // Enabled without a key: stays idle
        reset_n = 1'b1; enable = 1'b1;
        tick();
        check("nokey_drbg", drbg_reset_n, 256'd0);
        check("nokey_bypass", bypass, 256'd1);

        // Zero key is a valid key
        key_load = 1'b1; key_in = 256'd0;
        tick();
        key_load = 1'b0;
        check("k0_drbg_rst1", drbg_reset_n, 256'd0);
        tick();
        check("k0_drbg_rst2", drbg_reset_n, 256'd0);
        tick();
        check("k0_drbg_up", drbg_reset_n, 256'd1);
        check("k0_bypass_wi", bypass, 256'd1);
        repeat (49) tick();
        check("wi_fault", fault, 256'd0);
        init_ready = 1'b1;
        tick();
        init_ready = 1'b0;
        check("wf_bypass", bypass, 256'd1);
        check("wf_rot", rotator_reset_n, 256'd0);

        // Field 1 rise must not start the session
        V = 1'b1; F = 1'b1;
        tick();
        check("wf_f1_bypass", bypass, 256'd1);
        V = 1'b0; F = 1'b0;
        tick(); tick();
        V = 1'b1;
        tick();
        check("run_bypass", bypass, 256'd0);
        check("run_rot", rotator_reset_n, 256'd1);
        check("run_fc", field_count, 256'd0);
        check("run_seed", next_seed, 256'd0);

        // Six fields, reseed every second field
        for (int i = 1; i <= 6; i++) field(i, (i % 2) == 0);
        field(7, 1'b0);

        // Busy blocks the reseed of field 8
        generator_busy = 1'b1;
        field(8, 1'b0);
        V = 1'b0;
        repeat (3) tick();
        V = 1'b1;
        tick();
`ifdef SCRAMBLER_CTRL_WATCHDOG_EN
        check("wd_fault", fault, 256'd1);
        check("wd_bypass", bypass, 256'd1);
        generator_busy = 1'b0;
        tick();
        check("wd_noseed", next_seed, 256'd0);
`else
        check("busy_fc9", field_count, 256'd9);
        check("busy_nofault", fault, 256'd0);
        check("busy_seed_held", next_seed, 256'd0);
        generator_busy = 1'b0;
        tick();
        check("busy_seed_release", next_seed, 256'd1);
        tick();
        check("busy_seed_once", next_seed, 256'd0);
`endif

        // key_load coincident with V rise
        V = 1'b0;
        tick(); tick();
        V = 1'b1; key_load = 1'b1; key_in = K1;
        tick();
        key_load = 1'b0;
        check("kl_seed", next_seed, 256'd0);
        check("kl_fc", field_count, 256'd0);
        check("kl_entropy", entropy, K1);
        check("kl_drbg", drbg_reset_n, 256'd0);
        check("kl_bypass", bypass, 256'd1);
        check("kl_fault", fault, 256'd0);
        tick();
        tick();
        check("kl_drbg_up", drbg_reset_n, 256'd1);
        init_ready = 1'b1;
        tick();
        init_ready = 1'b0;
        V = 1'b0;
        tick();
        V = 1'b1; F = 1'b0;
        tick();
        check("kl_run_bypass", bypass, 256'd0);

        // Enable drop mid-line, then re-enable re-inits
        enable = 1'b0;
        tick();
        check("en0_bypass", bypass, 256'd1);
        check("en0_rot", rotator_reset_n, 256'd0);
        check("en0_drbg", drbg_reset_n, 256'd0);
        check("en0_entropy", entropy, K1);
        enable = 1'b1;
        tick();
        check("en1_drbg_rst", drbg_reset_n, 256'd0);
        tick();
        check("en1_drbg_rst2", drbg_reset_n, 256'd0);
        tick();
        check("en1_drbg_up", drbg_reset_n, 256'd1);

        // Init timeout: fault on cycle 4096 of WAIT_INIT
        repeat (4095) tick();
        check("tmo_not_yet", fault, 256'd0);
        tick();
        check("tmo_fault", fault, 256'd1);
        check("tmo_bypass", bypass, 256'd1);
        check("tmo_drbg", drbg_reset_n, 256'd0);
        repeat (5) tick();
        check("tmo_sticky", fault, 256'd1);

        // key_load clears the fault and re-inits
        key_load = 1'b1; key_in = K2;
        tick();
        key_load = 1'b0;
        check("clr_fault", fault, 256'd0);
        check("clr_entropy", entropy, K2);
        check("clr_drbg", drbg_reset_n, 256'd0);
        tick(); tick();
        check("clr_drbg_up", drbg_reset_n, 256'd1);
        init_ready = 1'b1;
        tick();
        init_ready = 1'b0;
        check("clr_wf_bypass", bypass, 256'd1);

        // Reset clears the key: enable alone must not restart
        reset_n = 1'b0;
        tick();
        check("rst2_entropy", entropy, 256'd0);
        check("rst2_drbg", drbg_reset_n, 256'd0);
        reset_n = 1'b1;
        repeat (3) tick();
        check("rst2_idle_drbg", drbg_reset_n, 256'd0);
        check("rst2_idle_bypass", bypass, 256'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
